// File: rtl/agex_branch_resolver.sv
// Branch/jump resolver in AGEX: registered redirect+squash to FE on a mispredict, and a predictor-update queue that FE drains.
// Latency: redirect/squash 1 cycle after the resolve; a queued update is visible on upd_* 1 cycle after its push (no bypass).
// Backpressure: upd_ready gates pops only; a push into a full queue with no pop is dropped and counted, never stalling AGEX.
module agex_branch_resolver #(
    parameter int DBITS         = 32,
    parameter int UPDQ_DEPTH    = 4,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic             br_is_cond,
    input  logic [DBITS-1:0] br_pc,
    input  logic [DBITS-1:0] br_pcplus,
    input  logic             br_taken,
    input  logic [DBITS-1:0] br_target,
    input  logic             pred_taken,
    input  logic [DBITS-1:0] pred_target,
    output logic             redirect_valid,
    output logic [DBITS-1:0] redirect_pc,
    output logic             squash,
    output logic             upd_valid,
    output logic [DBITS-1:0] upd_pc,
    output logic [DBITS-1:0] upd_target,
    output logic             upd_taken,
    input  logic             upd_ready,
    output logic [31:0]      stat_br,
    output logic [31:0]      stat_mispred,
    output logic [31:0]      stat_drop
);

    localparam int PW = (UPDQ_DEPTH < 2) ? 1 : $clog2(UPDQ_DEPTH);
    localparam int CW = $clog2(UPDQ_DEPTH + 1);
    localparam int SW = (SQUASH_CYCLES < 1) ? 1 : $clog2(SQUASH_CYCLES + 1);

    typedef struct packed {
        logic [DBITS-1:0] pc;
        logic             taken;
        logic [DBITS-1:0] target;
    } upd_entry_t;

    upd_entry_t       q_mem [UPDQ_DEPTH];
    upd_entry_t       q_head;
    upd_entry_t       push_dat;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    q_count;
    logic [SW-1:0]    squash_cnt;

    logic [DBITS-1:0] act_pc;
    logic [DBITS-1:0] pred_pc;
    logic             accepted;
    logic             mispred;
    logic             push_req;
    logic             q_full;
    logic             pop;
    logic             push;
    logic             drop;

    // Resolve the real and predicted next PCs and decide what this resolve does.
    always_comb begin
        act_pc   = (br_is_cond && !br_taken) ? br_pcplus : br_target;
        pred_pc  = pred_taken ? pred_target : br_pcplus;
        accepted = br_valid && (squash_cnt == '0);
        mispred  = accepted && (act_pc != pred_pc);
        push_req = accepted && br_is_cond;
        q_full   = (q_count == CW'(UPDQ_DEPTH));
        pop      = upd_valid && upd_ready;
        push     = push_req && (!q_full || pop);
        drop     = push_req && !push;
        push_dat = '{pc: br_pc, taken: (act_pc == br_target) && br_taken, target: br_target};
    end

    // Redirect/squash pulse and the wrong-path window that follows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            squash         <= 1'b0;
            redirect_pc    <= '0;
            squash_cnt     <= '0;
        end else begin
            redirect_valid <= mispred;
            squash         <= mispred;
            if (mispred) begin
                redirect_pc <= act_pc;
                squash_cnt  <= SW'(SQUASH_CYCLES);
            end else if (squash_cnt != '0) begin
                squash_cnt  <= squash_cnt - SW'(1);
            end
        end
    end

    // Queue pointers and occupancy; a full queue still accepts a push when the head pops this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            q_count <= q_count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage; contents are don't-care until the count says an entry is live.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= push_dat;
    end

    // Statistics counters, free-running and wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_br      <= '0;
            stat_mispred <= '0;
            stat_drop    <= '0;
        end else begin
            if (push_req) stat_br      <= stat_br + 32'd1;
            if (mispred)  stat_mispred <= stat_mispred + 32'd1;
            if (drop)     stat_drop    <= stat_drop + 32'd1;
        end
    end

    // Head outputs are forced to zero while empty so reset clears them asynchronously.
    assign q_head     = q_mem[rd_ptr];
    assign upd_valid  = (q_count != '0);
    assign upd_pc     = upd_valid ? q_head.pc     : '0;
    assign upd_target = upd_valid ? q_head.target : '0;
    assign upd_taken  = upd_valid && q_head.taken;

endmodule

// File: tb/tb_agex_branch_resolver.sv
module tb_agex_branch_resolver;

    logic        clk;
    logic        reset;
    logic        br_valid;
    logic        br_is_cond;
    logic [31:0] br_pc;
    logic [31:0] br_pcplus;
    logic        br_taken;
    logic [31:0] br_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        squash;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_ready;
    logic [31:0] stat_br;
    logic [31:0] stat_mispred;
    logic [31:0] stat_drop;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_br   = 0;
    logic [31:0] exp_mis  = 0;
    logic [31:0] exp_drop = 0;

    typedef struct {
        logic        cond;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        ptaken;
        logic [31:0] ptarget;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_push;
        logic        exp_utaken;
    } vec_t;

    vec_t vecs [9];

    agex_branch_resolver #(
        .DBITS(32), .UPDQ_DEPTH(4), .SQUASH_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .br_valid(br_valid), .br_is_cond(br_is_cond), .br_pc(br_pc),
        .br_pcplus(br_pcplus), .br_taken(br_taken), .br_target(br_target),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .squash(squash),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_ready(upd_ready),
        .stat_br(stat_br), .stat_mispred(stat_mispred), .stat_drop(stat_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic cond, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        br_valid    = 1'b1;
        br_is_cond  = cond;
        br_pc       = pc;
        br_pcplus   = pc + 32'd4;
        br_taken    = tk;
        br_target   = tgt;
        pred_taken  = ptk;
        pred_target = ptgt;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_stat_br"}, stat_br, exp_br);
        chk({tag, "_stat_mispred"}, stat_mispred, exp_mis);
        chk({tag, "_stat_drop"}, stat_drop, exp_drop);
    endtask

    initial begin
        //          cond  pc            tk    target        ptk   ptarget       redir rpc           push  utaken
        vecs[0] = '{1'b1, 32'h00000100, 1'b0, 32'h00000180, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h00000200, 1'b1, 32'h00000080, 1'b0, 32'h00000000, 1'b1, 32'h00000080, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 32'h00000300, 1'b0, 32'h00000400, 1'b1, 32'h00000404, 1'b1, 32'h00000400, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h00000500, 1'b0, 32'h00000600, 1'b1, 32'h00000600, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h00000700, 1'b1, 32'h00000740, 1'b1, 32'h00000740, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h00000800, 1'b0, 32'h00000900, 1'b1, 32'h00000900, 1'b1, 32'h00000804, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h00000900, 1'b0, 32'h00000904, 1'b1, 32'h00000904, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h00000A00, 1'b0, 32'h00000A04, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 32'hFFFFFFFC, 1'b1, 32'h00000000, 1'b1, 32'h80000000, 1'b1, 32'h00000000, 1'b1, 1'b1};

        reset = 1'b0;
        upd_ready = 1'b0;
        set_br(1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 32'h0);
        br_valid = 1'b0;

        // Reset held with resolves toggling: nothing may leak out.
        for (int i = 0; i < 3; i++) begin
            br_valid = (i % 2 == 0);
            tick;
            chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
            chk("rst_squash", {31'd0, squash}, 32'd0);
            chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        end
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk_stats("rst");

        reset = 1'b1;
        br_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("idle_redirect", {31'd0, redirect_valid}, 32'd0);
            chk("idle_upd_valid", {31'd0, upd_valid}, 32'd0);
        end
        chk_stats("idle");

        // Table: each resolve in isolation, queue draining immediately.
        upd_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_br(vecs[i].cond, vecs[i].pc, vecs[i].taken, vecs[i].target,
                   vecs[i].ptaken, vecs[i].ptarget);
            tick;
            br_valid = 1'b0;
            if (vecs[i].exp_push)  exp_br++;
            if (vecs[i].exp_redir) exp_mis++;
            chk($sformatf("v%0d_redirect", i), {31'd0, redirect_valid}, {31'd0, vecs[i].exp_redir});
            chk($sformatf("v%0d_squash", i), {31'd0, squash}, {31'd0, vecs[i].exp_redir});
            if (vecs[i].exp_redir)
                chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
            chk($sformatf("v%0d_upd_valid", i), {31'd0, upd_valid}, {31'd0, vecs[i].exp_push});
            if (vecs[i].exp_push) begin
                chk($sformatf("v%0d_upd_pc", i), upd_pc, vecs[i].pc);
                chk($sformatf("v%0d_upd_target", i), upd_target, vecs[i].target);
                chk($sformatf("v%0d_upd_taken", i), {31'd0, upd_taken}, {31'd0, vecs[i].exp_utaken});
            end
            chk_stats($sformatf("v%0d", i));
            tick;
            chk($sformatf("v%0d_redirect_pulse", i), {31'd0, redirect_valid}, 32'd0);
            chk($sformatf("v%0d_squash_pulse", i), {31'd0, squash}, 32'd0);
            chk($sformatf("v%0d_popped", i), {31'd0, upd_valid}, 32'd0);
            tick;
            tick;
        end

        // Wrong-path window: two resolves ignored, the third accepted.
        set_br(1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 32'h0);
        tick;
        exp_br++;
        exp_mis++;
        chk("wp_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("wp_redirect_pc", redirect_pc, 32'h80);
        set_br(1'b1, 32'h300, 1'b1, 32'h90, 1'b0, 32'h0);
        tick;
        chk("wp1_redirect", {31'd0, redirect_valid}, 32'd0);
        chk_stats("wp1");
        set_br(1'b1, 32'h310, 1'b1, 32'hA0, 1'b0, 32'h0);
        tick;
        chk("wp2_redirect", {31'd0, redirect_valid}, 32'd0);
        chk_stats("wp2");
        set_br(1'b1, 32'h320, 1'b0, 32'hB0, 1'b0, 32'h0);
        tick;
        br_valid = 1'b0;
        exp_br++;
        chk("wp3_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("wp3_upd_valid", {31'd0, upd_valid}, 32'd1);
        chk("wp3_upd_pc", upd_pc, 32'h320);
        chk_stats("wp3");
        tick;
        chk("wp_drained", {31'd0, upd_valid}, 32'd0);

        // Overflow: six pushes into a stalled queue keep the first four in order.
        upd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_br(1'b1, 32'h1000 + 32'(16 * i), 1'b0, 32'h2000, 1'b0, 32'h0);
            tick;
        end
        br_valid = 1'b0;
        exp_br += 6;
        exp_drop += 2;
        chk_stats("ovf");
        upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_pop%0d_valid", i), {31'd0, upd_valid}, 32'd1);
            chk($sformatf("ovf_pop%0d_pc", i), upd_pc, 32'h1000 + 32'(16 * i));
            tick;
        end
        chk("ovf_empty", {31'd0, upd_valid}, 32'd0);

        // Full queue with a simultaneous pop accepts the push at the tail.
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_br(1'b1, 32'h2000 + 32'(16 * i), 1'b0, 32'h3000, 1'b0, 32'h0);
            tick;
        end
        upd_ready = 1'b1;
        set_br(1'b1, 32'h2040, 1'b0, 32'h3000, 1'b0, 32'h0);
        tick;
        upd_ready = 1'b0;
        chk("pp_stat_drop", stat_drop, exp_drop);
        chk("pp_head", upd_pc, 32'h2010);
        set_br(1'b1, 32'h2050, 1'b0, 32'h3000, 1'b0, 32'h0);
        tick;
        br_valid = 1'b0;
        exp_br += 6;
        exp_drop++;
        chk_stats("pp");
        upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_pop%0d_valid", i), {31'd0, upd_valid}, 32'd1);
            chk($sformatf("pp_pop%0d_pc", i), upd_pc, 32'h2010 + 32'(16 * i));
            tick;
        end
        chk("pp_empty", {31'd0, upd_valid}, 32'd0);

        // Asynchronous reset while squashing with a queued entry.
        upd_ready = 1'b0;
        set_br(1'b1, 32'h3000, 1'b1, 32'h3800, 1'b0, 32'h0);
        tick;
        br_valid = 1'b0;
        chk("ar_pre_squash", {31'd0, squash}, 32'd1);
        chk("ar_pre_upd_valid", {31'd0, upd_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_squash", {31'd0, squash}, 32'd0);
        chk("ar_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("ar_redirect_pc", redirect_pc, 32'd0);
        chk("ar_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("ar_upd_pc", upd_pc, 32'd0);
        exp_br = 0;
        exp_mis = 0;
        exp_drop = 0;
        chk_stats("ar");
        @(negedge clk);
        reset = 1'b1;
        set_br(1'b1, 32'h4000, 1'b1, 32'h4100, 1'b0, 32'h0);
        tick;
        br_valid = 1'b0;
        chk("ar_restart_stat_br", stat_br, 32'd1);
        chk("ar_restart_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("ar_restart_redirect_pc", redirect_pc, 32'h4100);
        tick;
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
